// File: rtl/rv.sv
// rtl/rv.sv - RV32I decode types, opcodes and decoded-entry struct
// Package rv: instruction-type, opcode, ALU funct3 and ALU operand-select
// enums plus rv_decoded_t, the packed record carried from decode to execute.
package rv;

    typedef enum logic [2:0] {
        TYPE_R    = 3'd0,
        TYPE_I    = 3'd1,
        TYPE_S    = 3'd2,
        TYPE_B    = 3'd3,
        TYPE_U    = 3'd4,
        TYPE_J    = 3'd5,
        TYPE_NONE = 3'd6
    } RV32_INSTR_TYPE;

    typedef enum logic [6:0] {
        OPC_LUI      = 7'b0110111,
        OPC_AUIPC    = 7'b0010111,
        OPC_JAL      = 7'b1101111,
        OPC_JALR     = 7'b1100111,
        OPC_BRANCH   = 7'b1100011,
        OPC_LOAD     = 7'b0000011,
        OPC_STORE    = 7'b0100011,
        OPC_OP_IMM   = 7'b0010011,
        OPC_OP       = 7'b0110011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_SYSTEM   = 7'b1110011
    } RV32_INSTRUCTION_OPCODE;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SR   = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } RV32_ALU_OPCODE;

    typedef enum logic {
        ALU_MUX_RS2 = 1'b0,
        ALU_MUX_IMM = 1'b1
    } RV32_ALU_INPUT;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0]    pc;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic [4:0]     rd;
        logic           rd_we;
        logic [31:0]    imm;
        RV32_ALU_OPCODE funct3;
        logic [6:0]     funct7;
        RV32_ALU_INPUT  alu_second_input;
        RV32_INSTR_TYPE instr_type;
        logic           illegal;
    } rv_decoded_t;

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshakes of decode_stage
// master (fetch/execute side): drives in_valid, in_instr, in_pc, out_ready.
// slave  (decode_stage):       drives in_ready, out_valid, out_dec.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    import rv::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    rv_decoded_t       out_dec;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_dec
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_dec
    );
endinterface

// File: rtl/rv32_decode_core.sv
// rtl/rv32_decode_core.sv - combinational RV32I instruction decode
// Ports: instr (32-bit word), pc (its address) in; dec (rv_decoded_t) out.
// Register fields, funct3/funct7 are passed raw; consumers qualify them by
// instr_type.
module rv32_decode_core
    import rv::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output rv_decoded_t dec
);
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec                  = '0;
        dec.pc               = pc;
        dec.rs1              = instr[19:15];
        dec.rs2              = instr[24:20];
        dec.rd               = instr[11:7];
        dec.funct3           = RV32_ALU_OPCODE'(f3);
        dec.funct7           = f7;
        dec.alu_second_input = ALU_MUX_RS2;
        dec.instr_type       = TYPE_NONE;
        dec.imm              = '0;
        dec.rd_we            = 1'b0;
        dec.illegal          = 1'b0;

        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec.instr_type       = TYPE_U;
                dec.imm              = imm_u;
                dec.rd_we            = 1'b1;
                dec.alu_second_input = ALU_MUX_IMM;
            end
            OPC_JAL: begin
                dec.instr_type = TYPE_J;
                dec.imm        = imm_j;
                dec.rd_we      = 1'b1;
            end
            OPC_JALR: begin
                dec.instr_type       = TYPE_I;
                dec.imm              = imm_i;
                dec.rd_we            = 1'b1;
                dec.alu_second_input = ALU_MUX_IMM;
                dec.illegal          = (f3 != 3'b000);
            end
            OPC_LOAD: begin
                dec.instr_type       = TYPE_I;
                dec.imm              = imm_i;
                dec.rd_we            = 1'b1;
                dec.alu_second_input = ALU_MUX_IMM;
            end
            OPC_OP_IMM: begin
                dec.instr_type       = TYPE_I;
                dec.imm              = imm_i;
                dec.rd_we            = 1'b1;
                dec.alu_second_input = ALU_MUX_IMM;
                // Shifts reuse imm[11:5] as a funct7: only SRAI may set it.
                if (f3 == 3'b001)
                    dec.illegal = (f7 != FUNCT7_BASE);
                else if (f3 == 3'b101)
                    dec.illegal = (f7 != FUNCT7_BASE) && (f7 != FUNCT7_ALT);
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                dec.instr_type = TYPE_I;
                dec.imm        = imm_i;
            end
            OPC_STORE: begin
                dec.instr_type       = TYPE_S;
                dec.imm              = imm_s;
                dec.alu_second_input = ALU_MUX_IMM;
            end
            OPC_BRANCH: begin
                dec.instr_type = TYPE_B;
                dec.imm        = imm_b;
            end
            OPC_OP: begin
                dec.instr_type = TYPE_R;
                dec.rd_we      = 1'b1;
                // Alternate funct7 only exists for SUB and SRA.
                dec.illegal = !((f7 == FUNCT7_BASE) ||
                                ((f7 == FUNCT7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            default: dec.illegal = 1'b1;
        endcase

        if (instr[1:0] != 2'b11)
            dec.illegal = 1'b1;

        // x0 writes are dropped here so execute never needs to check rd.
        if (dec.illegal || (dec.rd == 5'd0))
            dec.rd_we = 1'b0;
    end
endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered elastic RV32I decode stage with in-order buffer
// Ports: clk, rst_n (async active-low), flush; bus (decode_stage_if.slave)
// carrying in_valid/in_ready/in_instr/in_pc and out_valid/out_ready/out_dec.
// Optional macro RV32_DECODE_STATS_EN adds stat_decoded / stat_illegal
// accept counters (wrap at 2^32, reset-cleared, untouched by flush).
module decode_stage
    import rv::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    decode_stage_if.slave      bus
`ifdef RV32_DECODE_STATS_EN
    ,
    output logic [31:0]        stat_decoded,
    output logic [31:0]        stat_illegal
`endif
);
    if (XLEN != 32) begin : g_bad_xlen
        $error("decode_stage: only XLEN=32 is supported");
    end
    if ((DEPTH < 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("decode_stage: DEPTH must be a power of 2 and at least 1");
    end

    // A 1-deep buffer still gets a 1-bit pointer; it simply never leaves 0.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    rv_decoded_t       in_dec;
    rv_decoded_t       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              accept, push, pop;

    rv32_decode_core u_core (
        .instr (bus.in_instr),
        .pc    (bus.in_pc),
        .dec   (in_dec)
    );

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // in_ready depends on registered count only, so a full buffer cannot
    // take a push in the same cycle it is popped.
    assign bus.in_ready  = (count < CNT_W'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign bus.out_dec   = bus.out_valid ? mem[rd_ptr] : '0;

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && !flush;
    assign pop    = bus.out_valid && bus.out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: out_dec is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_dec;
    end

`ifdef RV32_DECODE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_decoded <= '0;
            stat_illegal <= '0;
        end else begin
            if (accept)
                stat_decoded <= stat_decoded + 32'd1;
            if (accept && in_dec.illegal)
                stat_illegal <= stat_illegal + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard testbench for decode_stage
module tb_decode_stage;
    import rv::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
`ifdef RV32_DECODE_STATS_EN
    logic [31:0] stat_decoded, stat_illegal;
`endif

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
`ifdef RV32_DECODE_STATS_EN
        ,
        .stat_decoded (stat_decoded),
        .stat_illegal (stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    rv_decoded_t sb[$];
    logic [31:0] ins_tab [8];
    rv_decoded_t exp_tab [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    function automatic rv_decoded_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] rd, input logic we,
                                       input logic [31:0] imm, input RV32_ALU_OPCODE f3,
                                       input logic [6:0] f7, input RV32_ALU_INPUT alu,
                                       input RV32_INSTR_TYPE ty, input logic ill);
        rv_decoded_t d;
        d.pc = '0; d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.rd_we = we; d.imm = imm;
        d.funct3 = f3; d.funct7 = f7; d.alu_second_input = alu; d.instr_type = ty;
        d.illegal = ill;
        return d;
    endfunction

    // Hand-decoded expectations for each directed instruction word.
    initial begin
        ins_tab[0] = 32'hFFF10093; exp_tab[0] = mk(5'd2, 5'd31, 5'd1, 1'b1, 32'hFFFFFFFF, ALU_ADD, 7'h7F, ALU_MUX_IMM, TYPE_I, 1'b0);
        ins_tab[1] = 32'h00112223; exp_tab[1] = mk(5'd2, 5'd1, 5'd4, 1'b0, 32'h00000004, ALU_SLT, 7'h00, ALU_MUX_IMM, TYPE_S, 1'b0);
        ins_tab[2] = 32'hFE000EE3; exp_tab[2] = mk(5'd0, 5'd0, 5'd29, 1'b0, 32'hFFFFFFFC, ALU_ADD, 7'h7F, ALU_MUX_RS2, TYPE_B, 1'b0);
        ins_tab[3] = 32'h00000000; exp_tab[3] = mk(5'd0, 5'd0, 5'd0, 1'b0, 32'h00000000, ALU_ADD, 7'h00, ALU_MUX_RS2, TYPE_NONE, 1'b1);
        ins_tab[4] = 32'h40001033; exp_tab[4] = mk(5'd0, 5'd0, 5'd0, 1'b0, 32'h00000000, ALU_SLL, 7'h20, ALU_MUX_RS2, TYPE_R, 1'b1);
        ins_tab[5] = 32'h00000013; exp_tab[5] = mk(5'd0, 5'd0, 5'd0, 1'b0, 32'h00000000, ALU_ADD, 7'h00, ALU_MUX_IMM, TYPE_I, 1'b0);
        ins_tab[6] = 32'h123450B7; exp_tab[6] = mk(5'd8, 5'd3, 5'd1, 1'b1, 32'h12345000, ALU_SR, 7'h09, ALU_MUX_IMM, TYPE_U, 1'b0);
        ins_tab[7] = 32'h008000EF; exp_tab[7] = mk(5'd0, 5'd8, 5'd1, 1'b1, 32'h00000008, ALU_ADD, 7'h00, ALU_MUX_RS2, TYPE_J, 1'b0);
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int idx, input logic [31:0] pc);
        rv_decoded_t e;
        bit accepted = 1'b0;
        int t = 0;
        e = exp_tab[idx];
        e.pc = pc;
        bus.in_valid = 1'b1;
        bus.in_instr = ins_tab[idx];
        bus.in_pc    = pc;
        while (!accepted && t < 200) begin
            @(negedge clk);
            if (bus.in_ready) begin
                accepted = 1'b1;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            t++;
        end
        bus.in_valid = 1'b0;
        if (!accepted) check("send_timeout", 128'(accepted), 128'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every popped entry against the scoreboard head.
    initial begin
        rv_decoded_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_entry", 128'(bus.out_dec), 128'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_dec", 128'(bus.out_dec), 128'(e));
                end
            end
        end
    end

    initial begin
        #300000;
        check("global_timeout", 128'd1, 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        idle(3);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_in_ready",  128'(bus.in_ready),  128'd1);
        check("rst_out_dec",   128'(bus.out_dec),   128'd0);
        rst_n = 1'b1;
        idle(2);
        check("post_rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("post_rst_in_ready",  128'(bus.in_ready),  128'd1);

        // Decode vectors streaming with execute always ready.
        bus.out_ready = 1'b1;
        send(0, 32'h0000_1000);
        check("latency_out_valid", 128'(bus.out_valid), 128'd1);
        for (int i = 1; i < 8; i++) send(i, 32'h0000_1000 + 32'(i * 4));
        idle(4);
        check("stream_drained", 128'(sb.size()), 128'd0);

        // Backpressure: two fill the buffer, the third waits for a pop.
        bus.out_ready = 1'b0;
        send(6, 32'h0000_2000);
        send(1, 32'h0000_2004);
        check("full_in_ready", 128'(bus.in_ready), 128'd0);
        check("full_out_valid", 128'(bus.out_valid), 128'd1);
        fork
            send(7, 32'h0000_2008);
            begin
                idle(3);
                check("full_still_blocked", 128'(bus.in_ready), 128'd0);
                check("full_held_sb_size", 128'(sb.size()), 128'd2);
                bus.out_ready = 1'b1;
            end
        join
        idle(5);
        check("backpressure_drained", 128'(sb.size()), 128'd0);

        // Flush with the buffer full and an instruction on offer.
        bus.out_ready = 1'b0;
        send(0, 32'h0000_3000);
        send(2, 32'h0000_3004);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = ins_tab[6];
        bus.in_pc    = 32'h0000_3008;
        idle(1);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        check("flush_full_out_valid", 128'(bus.out_valid), 128'd0);
        check("flush_full_in_ready",  128'(bus.in_ready),  128'd1);
        check("flush_full_out_dec",   128'(bus.out_dec),   128'd0);

        // Flush with one entry and an acceptable offer: the offer is dropped.
        send(5, 32'h0000_3100);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = ins_tab[4];
        bus.in_pc    = 32'h0000_3104;
        idle(1);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        check("flush_accept_out_valid", 128'(bus.out_valid), 128'd0);
        bus.out_ready = 1'b1;
        send(7, 32'h0000_3200);
        idle(4);
        check("flush_drained", 128'(sb.size()), 128'd0);

        // Asynchronous reset with one entry buffered.
        bus.out_ready = 1'b0;
        send(1, 32'h0000_4000);
        check("pre_reset_out_valid", 128'(bus.out_valid), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("async_rst_in_ready",  128'(bus.in_ready),  128'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Five accepts after reset, two of them illegal.
        bus.out_ready = 1'b1;
        send(0, 32'h0000_5000);
        send(3, 32'h0000_5004);
        send(5, 32'h0000_5008);
        send(4, 32'h0000_500C);
        send(6, 32'h0000_5010);
        idle(4);
        check("final_drained", 128'(sb.size()), 128'd0);
`ifdef RV32_DECODE_STATS_EN
        check("stat_decoded", 128'(stat_decoded), 128'd5);
        check("stat_illegal", 128'(stat_illegal), 128'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
